// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: credit-limited in-order imem requests feeding a small instruction buffer
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] pc,
  input  logic        branch,
  input  logic        zero_flag,
  input  logic [31:0] pc_branch
);

  localparam int          AW      = $clog2(DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [31:0]   fetch_pc_q;
  logic [31:0]   rsp_pc_q;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr_q, wr_ptr_q;
  logic [31:0]   buf_data [DEPTH];
  logic [31:0]   buf_pc   [DEPTH];
  logic [31:0]   hold_data_q, hold_pc_q;
  logic [CW:0]   credit_used;
  logic [31:0]   target_pc;
  logic          accept, pop, redirect, rsp_drop, push;

  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? buf_data[rd_ptr_q] : hold_data_q;
  assign pc         = inst_valid ? buf_pc[rd_ptr_q]   : hold_pc_q;

  assign pop      = inst_valid & inst_ready;
  assign redirect = branch & zero_flag & pop;
  assign rsp_drop = (drop_q != '0);
  assign push     = imem_rsp_valid & ~rsp_drop & ~redirect;
  assign target_pc = {pc_branch[31:2], 2'b00};

  // A head popped this cycle frees its slot at the same edge, so a 1-cycle memory streams at full rate.
  assign credit_used    = {1'b0, outstanding_q} + {1'b0, count_q} - (CW+1)'(pop);
  assign imem_req_valid = rst_n & (state_q == RUN) & (credit_used < DEPTH_W);
  assign imem_req_addr  = fetch_pc_q;
  assign accept         = imem_req_valid & imem_req_ready;

  always_comb begin
    outstanding_d = outstanding_q + CW'(accept) - CW'(imem_rsp_valid);
    drop_d        = drop_q;
    if (imem_rsp_valid && rsp_drop) drop_d = drop_q - CW'(1);
    // Everything still in flight after this edge belongs to the abandoned path.
    if (redirect) drop_d = outstanding_d;
    state_d = state_q;
    case (state_q)
      RUN:   if (drop_d != '0) state_d = DRAIN;
      DRAIN: if (drop_d == '0) state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      drop_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      if (redirect) begin
        fetch_pc_q <= target_pc;
        rsp_pc_q   <= target_pc;
      end else begin
        if (accept) fetch_pc_q <= fetch_pc_q + 32'd4;
        if (push)   rsp_pc_q   <= rsp_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      hold_data_q <= '0;
      hold_pc_q   <= RESET_PC;
    end else begin
      hold_data_q <= inst_data;
      hold_pc_q   <= pc;
      if (redirect) begin
        count_q  <= '0;
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
        count_q <= count_q + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data[wr_ptr_q] <= imem_rsp_data;
      buf_pc[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && !rsp_drop && count_q == CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a queue-based fetch model
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, pc;
  logic        branch, zero_flag;
  logic [31:0] pc_branch;

  fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .pc(pc),
    .branch(branch), .zero_flag(zero_flag), .pc_branch(pc_branch)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; bit drop; } flight_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
  typedef struct { logic [31:0] data; int due; } mrsp_t;

  flight_t     flight_q[$];
  ent_t        buf_q[$];
  mrsp_t       mem_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] m_fetch_pc;
  int          cyc, last_due, lat_fixed, dut_pops;
  bit          lat_rand;
  int          vectors = 0;
  int          miscompares = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0F0F;
  endfunction

  function automatic bit draining();
    foreach (flight_q[i]) if (flight_q[i].drop) return 1'b1;
    return 1'b0;
  endfunction

  task automatic reset_assert();
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    inst_ready = 1'b0; branch = 1'b0; zero_flag = 1'b0; pc_branch = '0;
    flight_q.delete(); buf_q.delete(); mem_q.delete(); acc_q.delete();
    m_fetch_pc = RESET_PC; last_due = 0; cyc = 0;
  endtask

  task automatic reset_release();
    @(posedge clk); #1;
    rst_n = 1'b1; cyc = 0; last_due = 0;
  endtask

  task automatic start();
    reset_assert();
    reset_release();
  endtask

  task automatic tick(input bit rq_rdy, input bit in_rdy, input bit br, input bit zf, input logic [31:0] tgt);
    bit      rv, m_req_v, m_inst_v, m_pop, m_redir;
    int      due;
    flight_t f;
    ent_t    e;
    mrsp_t   r;
    imem_req_ready = rq_rdy; inst_ready = in_rdy; branch = br; zero_flag = zf; pc_branch = tgt;
    rv = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid = rv;
    if (rv) imem_rsp_data = mem_q[0].data;
    else    imem_rsp_data = $urandom;
    #1;
    m_inst_v = buf_q.size() > 0;
    m_pop    = m_inst_v && in_rdy;
    m_req_v  = !draining() && (flight_q.size() + buf_q.size() - int'(m_pop) < DEPTH);
    vectors++;
    if (imem_req_valid !== m_req_v) begin
      miscompares++;
      $display("FAIL req_valid cyc=%0d got=%b exp=%b", cyc, imem_req_valid, m_req_v);
    end
    vectors++;
    if (imem_req_addr !== m_fetch_pc) begin
      miscompares++;
      $display("FAIL req_addr cyc=%0d got=%h exp=%h", cyc, imem_req_addr, m_fetch_pc);
    end
    vectors++;
    if (inst_valid !== m_inst_v) begin
      miscompares++;
      $display("FAIL inst_valid cyc=%0d got=%b exp=%b", cyc, inst_valid, m_inst_v);
    end
    if (m_inst_v) begin
      vectors++;
      if (pc !== buf_q[0].pc || inst_data !== buf_q[0].data) begin
        miscompares++;
        $display("FAIL head cyc=%0d got pc=%h data=%h exp pc=%h data=%h",
                 cyc, pc, inst_data, buf_q[0].pc, buf_q[0].data);
      end
    end
    if (inst_valid && in_rdy) dut_pops++;
    // memory side: in-order responses, latency fixed or random
    if (imem_req_valid && rq_rdy) begin
      acc_q.push_back(imem_req_addr);
      due = cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat_fixed);
      if (due <= last_due) due = last_due + 1;
      r.data = mem_word(imem_req_addr); r.due = due;
      mem_q.push_back(r); last_due = due;
    end
    if (rv) mem_q.delete(0);
    // reference model update
    m_redir = m_pop && br && zf;
    if (m_pop) buf_q.delete(0);
    if (rv) begin
      if (flight_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_rsp cyc=%0d got=response exp=none", cyc);
      end else begin
        f = flight_q.pop_front();
        if (!f.drop && !m_redir) begin
          e.pc = f.addr; e.data = mem_word(f.addr);
          buf_q.push_back(e);
        end
      end
    end
    if (m_req_v && rq_rdy) begin
      f.addr = m_fetch_pc; f.drop = 1'b0;
      flight_q.push_back(f);
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (m_redir) begin
      buf_q.delete();
      foreach (flight_q[i]) flight_q[i].drop = 1'b1;
      m_fetch_pc = tgt & ~32'h3;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    vectors++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
      miscompares++;
      $display("FAIL %s_req got v=%b a=%h exp v=0 a=%h", tag, imem_req_valid, imem_req_addr, RESET_PC);
    end
    vectors++;
    if (inst_valid !== 1'b0 || inst_data !== 32'h0 || pc !== RESET_PC) begin
      miscompares++;
      $display("FAIL %s_inst got v=%b d=%h pc=%h exp v=0 d=0 pc=%h", tag, inst_valid, inst_data, pc, RESET_PC);
    end
  endtask

  task automatic run_to_head(input logic [31:0] want, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      if (buf_q.size() > 0 && buf_q[0].pc == want) hit = 1'b1;
      else tick(1, 1, 0, 0, 0);
    end
    if (!hit) begin
      vectors++; miscompares++;
      $display("FAIL timeout_head got=none exp=%h", want);
    end
  endtask

  task automatic expect_next_head(input logic [31:0] want, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (inst_valid) seen = 1'b1;
      else tick(1, 1, 0, 0, 0);
    end
    vectors++;
    if (!seen || pc !== want || inst_data !== mem_word(want)) begin
      miscompares++;
      $display("FAIL %s got v=%b pc=%h d=%h exp pc=%h d=%h", tag, seen, pc, inst_data, want, mem_word(want));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1; #2;
    reset_assert();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_release();
  endtask

  task automatic test_stream();
    lat_rand = 1'b0; lat_fixed = 1; dut_pops = 0;
    repeat (20) tick(1, 1, 0, 0, 0);
    vectors++;
    if (dut_pops !== 18) begin
      miscompares++;
      $display("FAIL stream_rate got=%0d exp=18", dut_pops);
    end
  endtask

  task automatic test_backpressure();
    start();
    repeat (5) tick(1, 0, 0, 0, 0);
    vectors++;
    if (imem_req_valid !== 1'b0 || inst_valid !== 1'b1 || pc !== RESET_PC) begin
      miscompares++;
      $display("FAIL stall got rv=%b iv=%b pc=%h exp rv=0 iv=1 pc=%h", imem_req_valid, inst_valid, pc, RESET_PC);
    end
    repeat (12) tick(1, 1, 0, 0, 0);
  endtask

  task automatic test_branch_taken();
    bit hit;
    start(); lat_fixed = 2;
    run_to_head(32'h8, hit);
    if (hit) begin
      tick(1, 1, 1, 1, 32'h40);
      acc_q.delete();
      expect_next_head(32'h40, "taken_head");
      vectors++;
      if (acc_q.size() < 2 || acc_q[0] !== 32'h40 || acc_q[1] !== 32'h44) begin
        miscompares++;
        $display("FAIL taken_reqs got n=%0d first=%h exp 40,44", acc_q.size(), acc_q.size() ? acc_q[0] : 32'hx);
      end
    end
    lat_fixed = 1;
  endtask

  task automatic test_not_taken();
    bit hit;
    start(); lat_fixed = 1;
    run_to_head(32'h8, hit);
    if (hit) begin
      tick(1, 1, 1, 0, 32'h40);
      expect_next_head(32'hC, "not_taken_head");
    end
  endtask

  task automatic test_redirect_same_cycle();
    bit hit;
    start(); lat_fixed = 1;
    run_to_head(32'h8, hit);
    if (hit) begin
      tick(1, 1, 1, 1, 32'h103);
      vectors++;
      if (imem_req_addr !== 32'h100 || imem_req_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL redir_drain got a=%h v=%b exp a=00000100 v=0", imem_req_addr, imem_req_valid);
      end
      acc_q.delete();
      expect_next_head(32'h100, "redir_head");
      vectors++;
      if (acc_q.size() == 0 || acc_q[0] !== 32'h100) begin
        miscompares++;
        $display("FAIL redir_first_req got n=%0d exp=00000100", acc_q.size());
      end
    end
  endtask

  task automatic test_wrap_and_reset();
    start(); lat_fixed = 1;
    for (int i = 0; i < 10; i++) begin
      if (buf_q.size() > 0) break;
      tick(1, 1, 0, 0, 0);
    end
    tick(1, 1, 1, 1, 32'hFFFF_FFFE);
    for (int i = 0; i < 10; i++) begin
      if (imem_req_valid) break;
      tick(0, 1, 0, 0, 0);
    end
    repeat (3) tick(0, 1, 0, 0, 0);
    vectors++;
    if (imem_req_addr !== 32'hFFFF_FFFC || imem_req_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_hold got a=%h v=%b exp a=fffffffc v=1", imem_req_addr, imem_req_valid);
    end
    tick(1, 1, 0, 0, 0);
    vectors++;
    if (imem_req_addr !== 32'h0) begin
      miscompares++;
      $display("FAIL wrap_next got=%h exp=00000000", imem_req_addr);
    end
    repeat (4) tick(1, 1, 0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    reset_assert();
    reset_release();
    repeat (4) tick(1, 1, 0, 0, 0);
    vectors++;
    if (acc_q.size() == 0 || acc_q[0] !== RESET_PC) begin
      miscompares++;
      $display("FAIL post_reset_req got n=%0d exp=%h", acc_q.size(), RESET_PC);
    end
  endtask

  task automatic test_random();
    start(); lat_rand = 1'b1;
    repeat (400) tick($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                      $urandom_range(0, 5) == 0, $urandom_range(0, 1) == 1,
                      32'($urandom_range(0, 4095)));
    lat_rand = 1'b0;
  endtask

  initial begin
    lat_rand = 1'b0; lat_fixed = 1; dut_pops = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_branch_taken();
    test_not_taken();
    test_redirect_same_cycle();
    test_wrap_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
